// File: rtl/dma_desc_pkg.sv
// dma_desc_pkg: engine state encoding, dword size and burst sizing shared by the DMA descriptor engine
package dma_desc_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, ARB = 3'd1, CALC = 3'd2, REQ = 3'd3} eng_state_e;
  localparam int DWORD_BYTES = 4;
  // Largest burst that fits the remaining length without leaving the current max_burst-dword block
  function automatic int unsigned burst_len(input int unsigned remain, input int unsigned rd_addr,
                                            input int unsigned max_burst);
    int unsigned room;
    room = max_burst - ((rd_addr / DWORD_BYTES) & (max_burst - 1));
    return remain < room ? remain : room;
  endfunction
endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin grant of the first requester at or after a pointer
module dma_rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CW-1:0]     o_next_ptr
);
  int w_idx;
  always_comb begin
    o_grant = '0;
    o_next_ptr = '0;
    w_idx = 0;
    // Scan farthest to nearest so the closest requester to i_ptr is written last
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM_CH;
      if (i_req[w_idx]) begin
        o_grant = NUM_CH'(1) << w_idx;
        o_next_ptr = CW'((w_idx + 1) % NUM_CH);
      end
    end
  end
endmodule

// File: rtl/dma_desc_engine.sv
// dma_desc_engine: multi-channel descriptor splitter issuing block-aligned bursts round-robin.
// Define DMA_DESC_ERR_EN to add req_err/ch_err and error aborts.
module dma_desc_engine
  import dma_desc_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int RD_ADDR_W = 16,
  parameter int WR_ADDR_W = 18,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 8,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(MAX_BURST) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           desc_valid,
  output logic [NUM_CH-1:0]           desc_ready,
  input  logic [NUM_CH*RD_ADDR_W-1:0] desc_rd_addr,
  input  logic [NUM_CH*WR_ADDR_W-1:0] desc_wr_addr,
  input  logic [NUM_CH*LEN_W-1:0]     desc_len,
  output logic                        req_valid,
  output logic [CW-1:0]               req_ch,
  output logic [RD_ADDR_W-1:0]        req_rd_addr,
  output logic [WR_ADDR_W-1:0]        req_wr_addr,
  output logic [LW-1:0]               req_len,
  input  logic                        req_ack,
`ifdef DMA_DESC_ERR_EN
  input  logic                        req_err,
  output logic [NUM_CH-1:0]           ch_err,
`endif
  output logic [NUM_CH-1:0]           ch_busy,
  output logic [NUM_CH-1:0]           ch_done,
  output logic [2:0]                  eng_state
);
  logic [RD_ADDR_W-1:0] r_rd [NUM_CH];
  logic [WR_ADDR_W-1:0] r_wr [NUM_CH];
  logic [LEN_W-1:0] r_remain [NUM_CH];
  logic [NUM_CH-1:0] r_busy, r_done;
  logic [CW-1:0] r_rr_ptr, r_req_ch;
  eng_state_e r_state;
  logic r_req_valid;
  logic [RD_ADDR_W-1:0] r_req_rd;
  logic [WR_ADDR_W-1:0] r_req_wr;
  logic [LW-1:0] r_req_len;
  logic [NUM_CH-1:0] w_acc, w_load, w_grant;
  logic [CW-1:0] w_gnt_idx, w_next_ptr;
  logic [LW-1:0] w_burst;
  logic w_ack, w_err;

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req(r_busy),
    .i_ptr(r_rr_ptr),
    .o_grant(w_grant),
    .o_next_ptr(w_next_ptr)
  );

  assign w_acc = desc_valid & ~r_busy;
  always_comb begin
    w_load = '0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_load[i] = w_acc[i] && desc_len[i*LEN_W +: LEN_W] != '0;
      if (w_grant[i]) w_gnt_idx = CW'(i);
    end
  end
  assign w_burst = LW'(burst_len(32'(r_remain[r_req_ch]), 32'(r_rd[r_req_ch]), MAX_BURST));
  assign w_ack = r_state == REQ && req_ack;

`ifdef DMA_DESC_ERR_EN
  logic [NUM_CH-1:0] r_err;
  assign w_err = req_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= '0;
    else r_err <= (r_err & ~w_acc) | ((w_ack && w_err) ? (NUM_CH'(1) << r_req_ch) : '0);
  end
  assign ch_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr_ptr <= '0;
      r_busy <= '0;
      r_done <= '0;
      r_req_valid <= 1'b0;
      r_req_ch <= '0;
      r_req_rd <= '0;
      r_req_wr <= '0;
      r_req_len <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_rd[i] <= '0;
        r_wr[i] <= '0;
        r_remain[i] <= '0;
      end
    end else begin
      r_done <= '0;
      // Zero-length descriptors complete immediately without ever becoming busy
      for (int i = 0; i < NUM_CH; i++)
        if (w_acc[i]) begin
          r_rd[i] <= desc_rd_addr[i*RD_ADDR_W +: RD_ADDR_W];
          r_wr[i] <= desc_wr_addr[i*WR_ADDR_W +: WR_ADDR_W];
          r_remain[i] <= desc_len[i*LEN_W +: LEN_W];
          r_busy[i] <= w_load[i];
          r_done[i] <= !w_load[i];
        end
      case (r_state)
        IDLE: if (|r_busy || |w_load) r_state <= ARB;
        ARB:
          if (|r_busy) begin
            r_req_ch <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
            r_state <= CALC;
          end else r_state <= IDLE;
        CALC: begin
          r_req_rd <= r_rd[r_req_ch];
          r_req_wr <= r_wr[r_req_ch];
          r_req_len <= w_burst;
          r_req_valid <= 1'b1;
          r_state <= REQ;
        end
        REQ:
          if (w_ack) begin
            r_req_valid <= 1'b0;
            r_state <= ARB;
            r_rd[r_req_ch] <= r_rd[r_req_ch] + RD_ADDR_W'(r_req_len) * RD_ADDR_W'(DWORD_BYTES);
            r_wr[r_req_ch] <= r_wr[r_req_ch] + WR_ADDR_W'(r_req_len) * WR_ADDR_W'(DWORD_BYTES);
            if (w_err || r_remain[r_req_ch] == LEN_W'(r_req_len)) begin
              r_remain[r_req_ch] <= '0;
              r_busy[r_req_ch] <= 1'b0;
              r_done[r_req_ch] <= 1'b1;
            end else r_remain[r_req_ch] <= r_remain[r_req_ch] - LEN_W'(r_req_len);
          end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign desc_ready = ~r_busy;
  assign ch_busy = r_busy;
  assign ch_done = r_done;
  assign req_valid = r_req_valid;
  assign req_ch = r_req_ch;
  assign req_rd_addr = r_req_rd;
  assign req_wr_addr = r_req_wr;
  assign req_len = r_req_len;
  assign eng_state = r_state;
endmodule
